// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between core LSU and external port
// Core wins by default; the external side gets idle cycles plus a bounded forced burst once starved.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req_i,
  input  logic                  c_we_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic [DATA_WIDTH-1:0] c_wdata_i,
  output logic                  c_gnt_o,
  output logic                  c_rvalid_o,
  output logic [DATA_WIDTH-1:0] c_rdata_o,
  output logic                  stall_o,
  input  logic                  e_req_i,
  input  logic                  e_we_i,
  input  logic [ADDR_WIDTH-1:0] e_addr_i,
  input  logic [DATA_WIDTH-1:0] e_wdata_i,
  output logic                  e_gnt_o,
  output logic                  e_rvalid_o,
  output logic [DATA_WIDTH-1:0] e_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_w_o,
  output logic [DATA_WIDTH-1:0] mem_d_o,
  input  logic [DATA_WIDTH-1:0] mem_q_i
);

  typedef enum logic {S_CORE, S_EXT} state_t;

  localparam logic [7:0] STARVE_MAX = STARVE_LIMIT[7:0];
  localparam logic [7:0] BURST_MAX  = MAX_BURST[7:0];

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] burst_q, burst_d;
  logic       owner_q, owner_d;
  logic       rd_pend_q, rd_pend_d;
  logic       c_gnt, e_gnt, ext_exit;
  logic [7:0] wait_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CORE;
      wait_q    <= 8'd0;
      burst_q   <= 8'd0;
      owner_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      burst_q   <= burst_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    c_gnt    = 1'b0;
    e_gnt    = 1'b0;
    ext_exit = 1'b0;
    state_d  = state_q;
    burst_d  = burst_q;
    if (!rst) begin
      case (state_q)
        S_CORE: begin
          if (c_req_i && e_req_i && (wait_q == STARVE_MAX)) begin
            e_gnt   = 1'b1;
            state_d = S_EXT;
            burst_d = 8'd1;
          end else if (c_req_i) begin
            c_gnt = 1'b1;
          end else if (e_req_i) begin
            e_gnt = 1'b1;
          end
        end
        S_EXT: begin
          if (e_req_i && (burst_q < BURST_MAX)) begin
            e_gnt   = 1'b1;
            burst_d = burst_q + 8'd1;
          end else begin
            // Leave the burst in the same cycle; an idle core still lets ext in.
            ext_exit = 1'b1;
            state_d  = S_CORE;
            burst_d  = 8'd0;
            if (c_req_i) begin
              c_gnt = 1'b1;
            end else if (e_req_i) begin
              e_gnt = 1'b1;
            end
          end
        end
        default: state_d = S_CORE;
      endcase
    end
  end

  // The denied cycle on burst exit already counts toward the next starvation window.
  always_comb begin
    wait_base = (e_gnt || ext_exit) ? 8'd0 : wait_q;
    wait_d    = wait_base;
    if (e_req_i && !e_gnt && !rst) begin
      wait_d = (wait_base >= STARVE_MAX) ? STARVE_MAX : wait_base + 8'd1;
    end
  end

  always_comb begin
    rd_pend_d = (c_gnt && !c_we_i) || (e_gnt && !e_we_i);
    owner_d   = e_gnt;
  end

  assign c_gnt_o    = c_gnt;
  assign e_gnt_o    = e_gnt;
  assign stall_o    = c_req_i && !c_gnt && !rst;
  assign mem_a_o    = e_gnt ? e_addr_i : c_addr_i;
  assign mem_d_o    = e_gnt ? e_wdata_i : c_wdata_i;
  assign mem_w_o    = (c_gnt && c_we_i) || (e_gnt && e_we_i);
  assign c_rvalid_o = rd_pend_q && !owner_q && !rst;
  assign e_rvalid_o = rd_pend_q && owner_q && !rst;
  assign c_rdata_o  = mem_q_i;
  assign e_rdata_o  = mem_q_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, e_req, e_we;
  logic [15:0] c_addr, e_addr;
  logic [31:0] c_wdata, e_wdata;
  logic        c_gnt, c_rvalid, stall, e_gnt, e_rvalid, mem_w;
  logic [31:0] c_rdata, e_rdata, mem_d, mem_q;
  logic [15:0] mem_a;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .STARVE_LIMIT(4), .MAX_BURST(2)) dut (
    .clk(clk), .rst(rst),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_gnt_o(c_gnt), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata), .stall_o(stall),
    .e_req_i(e_req), .e_we_i(e_we), .e_addr_i(e_addr), .e_wdata_i(e_wdata),
    .e_gnt_o(e_gnt), .e_rvalid_o(e_rvalid), .e_rdata_o(e_rdata),
    .mem_a_o(mem_a), .mem_w_o(mem_w), .mem_d_o(mem_d), .mem_q_i(mem_q)
  );

  always @(posedge clk) begin
    if (mem_w) mem[mem_a[7:0]] <= mem_d;
    mem_q <= mem[mem_a[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid pops one expected {owner, data} entry.
  always @(negedge clk) begin
    if (c_rvalid || e_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, e_rvalid, c_rvalid}, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rvalid_owner", {62'd0, e_rvalid, c_rvalid}, e[32] ? 64'd2 : 64'd1);
        chk("rdata", e[32] ? e_rdata : c_rdata, e[31:0]);
      end
    end
  end

  task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [31:0] cd,
                      input logic er, input logic ew, input logic [15:0] ea, input logic [31:0] ed);
    @(posedge clk);
    #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    e_req = er; e_we = ew; e_addr = ea; e_wdata = ed;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hCAFEF00D;
    rst = 1'b1;
    step(1, 1, 16'h0001, 32'h1, 1, 1, 16'h0002, 32'h2);
    chk("rst_c_gnt", c_gnt, 0); chk("rst_e_gnt", e_gnt, 0);
    chk("rst_stall", stall, 0); chk("rst_mem_w", mem_w, 0);
    step(1, 1, 16'h0001, 32'h1, 1, 1, 16'h0002, 32'h2);
    chk("rst_c_gnt2", c_gnt, 0); chk("rst_mem_w2", mem_w, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle();
    chk("post_rst_c_rvalid", c_rvalid, 0); chk("post_rst_e_rvalid", e_rvalid, 0);

    // Core read alone
    step(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    chk("core_rd_gnt", c_gnt, 1); chk("core_rd_stall", stall, 0);
    chk("core_rd_mem_a", mem_a, 16'h0010); chk("core_rd_mem_w", mem_w, 0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    idle();
    chk("core_rd_c_rvalid", c_rvalid, 1); chk("core_rd_e_rvalid", e_rvalid, 0);

    // External write alone
    step(0, 0, 16'h0, 32'h0, 1, 1, 16'h0020, 32'h12345678);
    chk("ext_wr_gnt", e_gnt, 1); chk("ext_wr_c_gnt", c_gnt, 0);
    chk("ext_wr_mem_w", mem_w, 1); chk("ext_wr_mem_a", mem_a, 16'h0020);
    chk("ext_wr_mem_d", mem_d, 32'h12345678);
    idle();
    chk("ext_wr_no_e_rvalid", e_rvalid, 0); chk("ext_wr_no_c_rvalid", c_rvalid, 0);

    // Steady contention: 4 core, 2 ext, repeating
    pat = 12'b1100_0011_0000;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 16'h0040, 32'(i), 1, 1, 16'h0050, 32'(i));
      chk($sformatf("cont_c_gnt_%0d", i), c_gnt, !pat[i]);
      chk($sformatf("cont_e_gnt_%0d", i), e_gnt, pat[i]);
      chk($sformatf("cont_stall_%0d", i), stall, pat[i]);
    end
    idle(); idle();

    // e_req drops after first forced ext grant
    for (int i = 0; i < 5; i++) step(1, 1, 16'h0041, 32'h0, 1, 1, 16'h0051, 32'h0);
    chk("drop_forced_e_gnt", e_gnt, 1);
    step(1, 1, 16'h0041, 32'h0, 0, 0, 16'h0, 32'h0);
    chk("drop_c_gnt", c_gnt, 1); chk("drop_e_gnt", e_gnt, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 16'h0041, 32'h0, 1, 1, 16'h0051, 32'h0);
      chk($sformatf("drop_after_e_gnt_%0d", i), e_gnt, i == 4);
    end
    idle(); idle();

    // Core read then ext read on consecutive cycles
    step(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
    chk("alt_c_gnt", c_gnt, 1);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    step(0, 0, 16'h0, 32'h0, 1, 0, 16'h0020, 32'h0);
    chk("alt_e_gnt", e_gnt, 1); chk("alt_c_rvalid", c_rvalid, 1);
    exp_q.push_back({1'b1, 32'h12345678});
    idle();
    chk("alt_e_rvalid", e_rvalid, 1); chk("alt_c_rvalid_off", c_rvalid, 0);
    idle();

    // Reset while in S_EXT with an ext read in flight
    for (int i = 0; i < 5; i++) step(1, 1, 16'h0042, 32'h0, 1, 0, 16'h0030, 32'h0);
    chk("rstx_forced_e_gnt", e_gnt, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rstx_c_gnt", c_gnt, 0); chk("rstx_e_gnt", e_gnt, 0);
    chk("rstx_stall", stall, 0); chk("rstx_mem_w", mem_w, 0);
    chk("rstx_e_rvalid", e_rvalid, 0);
    @(posedge clk); #1; rst = 1'b0;
    c_req = 1; c_we = 0; c_addr = 16'h0010; e_req = 0;
    @(negedge clk);
    chk("rstx_after_c_gnt", c_gnt, 1);
    chk("rstx_after_e_rvalid", e_rvalid, 0); chk("rstx_after_c_rvalid", c_rvalid, 0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    idle(); idle();

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
